// File: rtl/pipelined_adder.sv
// Elastic WIDTH-bit adder/subtractor; the carry chain is cut into STAGES chunks, one per clock.
// Define PIPELINED_ADDER_SAT_EN to add the Sat input that clamps overflowing results.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Cin,
`ifdef PIPELINED_ADDER_SAT_EN
  input  logic             Sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int CW  = WIDTH / STAGES;
  localparam int NOP = (STAGES > 1) ? STAGES - 1 : 1;

  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] carry_vec;
  logic [WIDTH-1:0]  psum_arr [STAGES];
  logic [WIDTH-1:0]  opa_arr  [NOP];
  logic [WIDTH-1:0]  opb_arr  [NOP];
`ifdef PIPELINED_ADDER_SAT_EN
  logic [NOP-1:0]    sat_vec;
`endif
  logic [WIDTH-1:0]  b_eff;

  assign b_eff = Sub ? ~B : B;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             v_in, c_in;
      logic [WIDTH-1:0] s_in, s_new, s_load;
      logic [CW-1:0]    a_ch, b_ch;
      logic [CW:0]      chunk;
      logic             v_q, v_d, c_q, c_d;
      logic [WIDTH-1:0] s_q, s_d;

      // A stage may load whenever some stage between it and the output has room.
      assign adv[gi] = out_ready || !(&valid_vec[STAGES-1:gi]);

      if (gi == 0) begin : g_src_port
        assign v_in = in_valid;
        assign c_in = Sub | Cin;
        assign s_in = '0;
        assign a_ch = A[CW-1:0];
        assign b_ch = b_eff[CW-1:0];
      end else begin : g_src_reg
        assign v_in = valid_vec[gi-1];
        assign c_in = carry_vec[gi-1];
        assign s_in = psum_arr[gi-1];
        assign a_ch = opa_arr[gi-1][CW-1:0];
        assign b_ch = opb_arr[gi-1][CW-1:0];
      end

      assign chunk = {1'b0, a_ch} + {1'b0, b_ch} + {{CW{1'b0}}, c_in};

      always_comb begin
        s_new = s_in;
        s_new[gi*CW +: CW] = chunk[CW-1:0];
      end

      always_comb begin
        v_d = adv[gi] ? v_in : v_q;
        c_d = c_q;
        s_d = s_q;
        if (adv[gi] && v_in) begin
          c_d = chunk[CW];
          s_d = s_load;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
        end else begin
          v_q <= v_d;
          c_q <= c_d;
          s_q <= s_d;
        end
      end

      assign valid_vec[gi] = v_q;
      assign carry_vec[gi] = c_q;
      assign psum_arr[gi]  = s_q;

      if (gi == STAGES - 1) begin : g_last
        logic ovf_c, ovf_q, ovf_d;

        // The final chunk holds both operand MSBs (B already inverted for Sub).
        assign ovf_c = (a_ch[CW-1] == b_ch[CW-1]) && (chunk[CW-1] != a_ch[CW-1]);

`ifdef PIPELINED_ADDER_SAT_EN
        logic sat_c;
        if (gi == 0) begin : g_sat_port
          assign sat_c = Sat;
        end else begin : g_sat_reg
          assign sat_c = sat_vec[gi-1];
        end
        always_comb begin
          s_load = s_new;
          if (sat_c && ovf_c)
            s_load = a_ch[CW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        assign s_load = s_new;
`endif

        always_comb begin
          ovf_d = ovf_q;
          if (adv[gi] && v_in) ovf_d = ovf_c;
        end

        always_ff @(posedge clk) begin
          if (rst) ovf_q <= 1'b0;
          else     ovf_q <= ovf_d;
        end

        assign Ovf = ovf_q;
      end else begin : g_mid
        logic [WIDTH-1:0] a_full, b_full;
        logic [WIDTH-1:0] a_q, a_d, b_q, b_d;

        if (gi == 0) begin : g_op_port
          assign a_full = A;
          assign b_full = b_eff;
        end else begin : g_op_reg
          assign a_full = opa_arr[gi-1];
          assign b_full = opb_arr[gi-1];
        end

        assign s_load = s_new;

        // Operands shift down so the next chunk always sits in the low CW bits.
        always_comb begin
          a_d = a_q;
          b_d = b_q;
          if (adv[gi] && v_in) begin
            a_d = a_full >> CW;
            b_d = b_full >> CW;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            a_q <= '0;
            b_q <= '0;
          end else begin
            a_q <= a_d;
            b_q <= b_d;
          end
        end

        assign opa_arr[gi] = a_q;
        assign opb_arr[gi] = b_q;

`ifdef PIPELINED_ADDER_SAT_EN
        logic sat_src, sat_q, sat_d;
        if (gi == 0) begin : g_sat_port
          assign sat_src = Sat;
        end else begin : g_sat_reg
          assign sat_src = sat_vec[gi-1];
        end
        always_comb begin
          sat_d = sat_q;
          if (adv[gi] && v_in) sat_d = sat_src;
        end
        always_ff @(posedge clk) begin
          if (rst) sat_q <= 1'b0;
          else     sat_q <= sat_d;
        end
        assign sat_vec[gi] = sat_q;
`endif
      end
    end

    if (STAGES == 1) begin : g_no_ops
      assign opa_arr[0] = '0;
      assign opb_arr[0] = '0;
`ifdef PIPELINED_ADDER_SAT_EN
      assign sat_vec[0] = 1'b0;
`endif
    end
  endgenerate

  assign in_ready  = adv[0];
  assign out_valid = valid_vec[STAGES-1];
  assign Sum       = psum_arr[STAGES-1];
  assign Cout      = carry_vec[STAGES-1];
  // Qualified by out_valid so the flag reads 0 out of reset, like the other flags.
  assign Zero      = out_valid && (Sum == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streaming checks for pipelined_adder at 32/4, 32/1, 32/32 and 8/2.
// Vectors for Sat expect clamping only when PIPELINED_ADDER_SAT_EN is defined.
module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0, cin = 1'b0, sat = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;
  logic        in_ready_s1, out_valid_s1, cout_s1, ovf_s1, zero_s1;
  logic [31:0] sum_s1;
  logic        in_ready_s32, out_valid_s32, cout_s32, ovf_s32, zero_s32;
  logic [31:0] sum_s32;
  logic        in_valid8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        in_ready8, out_valid8, cout8, ovf8, zero8;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .Sub(sub), .Cin(cin),
`ifdef PIPELINED_ADDER_SAT_EN
    .Sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .Cout(cout), .Ovf(ovf), .Zero(zero));

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s1), .A(a), .B(b),
    .Sub(sub), .Cin(cin),
`ifdef PIPELINED_ADDER_SAT_EN
    .Sat(sat),
`endif
    .out_valid(out_valid_s1), .out_ready(out_ready), .Sum(sum_s1), .Cout(cout_s1),
    .Ovf(ovf_s1), .Zero(zero_s1));

  pipelined_adder #(.WIDTH(32), .STAGES(32)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s32), .A(a), .B(b),
    .Sub(sub), .Cin(cin),
`ifdef PIPELINED_ADDER_SAT_EN
    .Sat(sat),
`endif
    .out_valid(out_valid_s32), .out_ready(out_ready), .Sum(sum_s32), .Cout(cout_s32),
    .Ovf(ovf_s32), .Zero(zero_s32));

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8),
    .Sub(sub), .Cin(cin),
`ifdef PIPELINED_ADDER_SAT_EN
    .Sat(sat),
`endif
    .out_valid(out_valid8), .out_ready(out_ready), .Sum(sum8), .Cout(cout8),
    .Ovf(ovf8), .Zero(zero8));

  // Reference results packed as {sum, cout, ovf, zero}.
  function automatic logic [34:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                        input logic s, input logic c);
    logic [31:0] ye;
    logic [32:0] r;
    logic        v;
    ye = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {32'd0, (s | c)};
    v  = (x[31] == ye[31]) && (r[31] != x[31]);
    return {r[31:0], r[32], v, (r[31:0] == 32'd0)};
  endfunction

  function automatic logic [10:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input logic s, input logic c);
    logic [7:0] ye;
    logic [8:0] r;
    logic       v;
    ye = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {8'd0, (s | c)};
    v  = (x[7] == ye[7]) && (r[7] != x[7]);
    return {r[7:0], r[8], v, (r[7:0] == 8'd0)};
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1; sat = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 32'd0) begin errors++; $display("FAIL reset_sum: got %h want 00000000", sum); end
    checks++; if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, zero}); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b want 0", out_valid); end
  endtask

  typedef struct packed {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vs;
    logic        vc;
    logic        vt;
    logic [34:0] exp;
  } dvec_t;

  task automatic test_directed();
    dvec_t dv [9];
    int    lat;
    dv[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, {32'h00000000, 3'b101}};
    dv[1] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0, {32'h7FFFFFFF, 3'b110}};
    dv[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b0, {32'hFFFFFFFE, 3'b000}};
    dv[3] = '{32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, {32'h80000000, 3'b010}};
    dv[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b0, {32'h2345678A, 3'b000}};
    dv[5] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, {32'h01000000, 3'b000}};
    dv[6] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, {32'h00000000, 3'b101}};
    dv[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, {32'h00000000, 3'b111}};
`ifdef PIPELINED_ADDER_SAT_EN
    dv[8] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1, {32'h80000000, 3'b110}};
`else
    dv[8] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1, {32'h7FFFFFFF, 3'b110}};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a = dv[i].va; b = dv[i].vb; sub = dv[i].vs; cin = dv[i].vc; sat = dv[i].vt;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; sat = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL directed[%0d]_latency: got %0d want 4", i, lat); end
      checks++;
      if ({sum, cout, ovf, zero} !== dv[i].exp) begin
        errors++;
        $display("FAIL directed[%0d]_result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                 i, sum, cout, ovf, zero, dv[i].exp[34:3], dv[i].exp[2], dv[i].exp[1], dv[i].exp[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] q [$];
    logic [34:0] exp;
    logic [31:0] ca, cb;
    logic        cs, cc;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    ca = $urandom; cb = $urandom; cs = 1'($urandom_range(0, 1)); cc = 1'($urandom_range(0, 1));
    while (got < 100 && cyc < 400) begin
      if (sent < 100) begin
        in_valid = 1'b1; a = ca; b = cb; sub = cs; cin = cc;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got sum=%h with no op outstanding", sum);
        end else begin
          exp = q.pop_front();
          if ({sum, cout, ovf, zero} !== exp)
            begin errors++; $display("FAIL stream[%0d]: got %h_%b%b%b want %h_%b", got, sum, cout, ovf, zero, exp[34:3], exp[2:0]); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref32(ca, cb, cs, cc));
        sent++;
        ca = $urandom; cb = $urandom; cs = 1'($urandom_range(0, 1)); cc = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (cyc !== 104) begin errors++; $display("FAIL stream_throughput: got %0d cycles want 104", cyc); end
  endtask

  task automatic test_backpressure();
    logic [34:0] q [$];
    logic [34:0] exp;
    logic [35:0] snap;
    logic [31:0] ca, cb;
    logic        cs, cc;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    ca = $urandom; cb = $urandom; cs = 1'($urandom_range(0, 1)); cc = 1'($urandom_range(0, 1));
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = ca; b = cb; sub = cs; cin = cc;
      #1;
      if (in_valid && in_ready) begin
        q.push_back(ref32(ca, cb, cs, cc));
        sent++;
        ca = $urandom; cb = $urandom; cs = 1'($urandom_range(0, 1)); cc = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    #1;
    checks++; if (sent !== 4) begin errors++; $display("FAIL stall_accepted: got %0d want 4", sent); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    checks++;
    if (!out_valid || q.size() == 0 || {sum, cout, ovf, zero} !== q[0])
      begin errors++; $display("FAIL stall_head: got v=%b %h_%b%b%b want v=1 oldest result", out_valid, sum, cout, ovf, zero); end
    snap = {out_valid, sum, cout, ovf, zero};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, sum, cout, ovf, zero} !== snap)
        begin errors++; $display("FAIL stall_stable[%0d]: got %h want %h", i, {out_valid, sum, cout, ovf, zero}, snap); end
    end
    while (got < 12 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 12) begin
        in_valid = 1'b1; a = ca; b = cb; sub = cs; cin = cc;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL drain_extra: got sum=%h with no op outstanding", sum);
        end else begin
          exp = q.pop_front();
          if ({sum, cout, ovf, zero} !== exp)
            begin errors++; $display("FAIL drain[%0d]: got %h_%b%b%b want %h_%b", got, sum, cout, ovf, zero, exp[34:3], exp[2:0]); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref32(ca, cb, cs, cc));
        sent++;
        ca = $urandom; cb = $urandom; cs = 1'($urandom_range(0, 1)); cc = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got !== 12 || q.size() !== 0)
      begin errors++; $display("FAIL drain_count: got %0d results, %0d pending want 12, 0", got, q.size()); end
  endtask

  task automatic test_reset_inflight();
    int seen;
    do_reset();
    out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'(i + 1); b = 32'h00000100;
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_pre: got %b want 0", out_valid); end
    rst = 1'b1; a = 32'h55; b = 32'h66;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 32'd0) begin errors++; $display("FAIL inflight_sum: got %h want 00000000", sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL inflight_in_ready: got %b want 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL inflight_stale: got %0d stale results want 0", seen); end
  endtask

  task automatic test_stage_sweep();
    int          l1, l4, l32;
    logic [34:0] r1, r4, r32;
    logic [34:0] exp;
    do_reset();
    l1 = 0; l4 = 0; l32 = 0; r1 = '0; r4 = '0; r32 = '0;
    exp = {32'h80000000, 3'b010};
    a = 32'h7FFFFFFF; b = 32'h00000001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (l1 == 0 && out_valid_s1) begin l1 = n; r1 = {sum_s1, cout_s1, ovf_s1, zero_s1}; end
      if (l4 == 0 && out_valid) begin l4 = n; r4 = {sum, cout, ovf, zero}; end
      if (l32 == 0 && out_valid_s32) begin l32 = n; r32 = {sum_s32, cout_s32, ovf_s32, zero_s32}; end
      @(posedge clk); #1;
    end
    checks++; if (l1 !== 1) begin errors++; $display("FAIL s1_latency: got %0d want 1", l1); end
    checks++; if (l4 !== 4) begin errors++; $display("FAIL s4_latency: got %0d want 4", l4); end
    checks++; if (l32 !== 32) begin errors++; $display("FAIL s32_latency: got %0d want 32", l32); end
    checks++; if (r1 !== exp) begin errors++; $display("FAIL s1_result: got %h want %h", r1, exp); end
    checks++; if (r4 !== exp) begin errors++; $display("FAIL s4_result: got %h want %h", r4, exp); end
    checks++; if (r32 !== exp) begin errors++; $display("FAIL s32_result: got %h want %h", r32, exp); end
  endtask

  task automatic test_w8_sweep();
    logic [10:0] q [$];
    logic [10:0] exp;
    logic [7:0]  bvals [5];
    int          lat, sent, got, cyc;
    bvals[0] = 8'h00; bvals[1] = 8'h01; bvals[2] = 8'h7F; bvals[3] = 8'h80; bvals[4] = 8'hFF;
    do_reset();
    a8 = 8'h7F; b8 = 8'h01; sub = 1'b0; cin = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL w8_latency: got %0d want 2", lat); end
    checks++;
    if ({sum8, cout8, ovf8, zero8} !== {8'h80, 3'b010})
      begin errors++; $display("FAIL w8_result: got %h_%b%b%b want 80_010", sum8, cout8, ovf8, zero8); end
    @(posedge clk); #1;
    sent = 0; got = 0; cyc = 0;
    while (got < 5120 && cyc < 6000) begin
      if (sent < 5120) begin
        in_valid8 = 1'b1; a8 = sent[7:0]; sub = sent[9]; cin = sent[8]; b8 = bvals[sent / 1024];
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (out_valid8 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL w8_extra: got sum=%h with no op outstanding", sum8);
        end else begin
          exp = q.pop_front();
          if ({sum8, cout8, ovf8, zero8} !== exp)
            begin errors++; $display("FAIL w8_sweep[%0d]: got %h_%b%b%b want %h_%b", got, sum8, cout8, ovf8, zero8, exp[10:3], exp[2:0]); end
        end
        got++;
      end
      if (in_valid8 && in_ready8) begin
        q.push_back(ref8(a8, b8, sub, cin));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid8 = 1'b0;
    checks++; if (cyc !== 5122) begin errors++; $display("FAIL w8_throughput: got %0d cycles want 5122", cyc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_stage_sweep();
    test_w8_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
